// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin IF/LS arbiter for the shared fixed-latency memory port
// Optional: define ARB_LS_PRIORITY_EN for fixed LS-over-IF priority on contention.
module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MEM_LAT = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_ack,
    output logic [DW-1:0] rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // cnt counts the remaining strobe cycles after the current one
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          we_q, we_d;
    logic          owner_q, owner_d;
    logic          last_owner_q, last_owner_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_wr_q, mem_wr_d;
    logic          if_ack_q, if_ack_d;
    logic          ls_ack_q, ls_ack_d;
    logic          busy_q, busy_d;
    logic          grant_ls;

    // Next-state, grant decision and registered-output values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        we_d         = we_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        if_ack_d     = 1'b0;
        ls_ack_d     = 1'b0;
        busy_d       = 1'b0;
        grant_ls     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (if_req || ls_req) begin
`ifdef ARB_LS_PRIORITY_EN
                    grant_ls = ls_req;
`else
                    // On contention the requester that did not go last wins
                    grant_ls = ls_req && (!if_req || !last_owner_q);
`endif
                    owner_d  = grant_ls;
                    addr_d   = grant_ls ? ls_addr : if_addr;
                    we_d     = grant_ls && ls_we;
                    wdata_d  = grant_ls ? ls_wdata : wdata_q;
                    cnt_d    = CNT_INIT;
                    mem_rd_d = !(grant_ls && ls_we);
                    mem_wr_d = grant_ls && ls_we;
                    busy_d   = 1'b1;
                    state_d  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                busy_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    last_owner_d = owner_q;
                    if_ack_d     = !owner_q;
                    ls_ack_d     = owner_q;
                    state_d      = S_RESP;
                end else begin
                    cnt_d    = cnt_q - 4'd1;
                    mem_rd_d = !we_q;
                    mem_wr_d = we_q;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            we_q         <= 1'b0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            if_ack_q     <= 1'b0;
            ls_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            we_q         <= we_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            if_ack_q     <= if_ack_d;
            ls_ack_q     <= ls_ack_d;
            busy_q       <= busy_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign ls_ack    = ls_ack_q;
    assign rdata     = rdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       if_req, ls_req, ls_we;
    logic [7:0] if_addr, ls_addr, ls_wdata;

    logic       if_ack0, ls_ack0, mem_rd0, mem_wr0, busy0, owner0;
    logic [7:0] rdata0, mem_addr0, mem_wdata0, mem_rdata0;
    logic       if_ack1, ls_ack1, mem_rd1, mem_wr1, busy1, owner1;
    logic [7:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;

    assign mem_rdata0 = mem[mem_addr0];
    assign mem_rdata1 = mem[mem_addr1];

    always #5 clock = ~clock;

    mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(2)) dut0 (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack0),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ack(ls_ack0),
        .rdata(rdata0), .mem_rd(mem_rd0), .mem_wr(mem_wr0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .busy(busy0), .owner(owner0)
    );

    mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(1)) dut1 (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack1),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ack(ls_ack1),
        .rdata(rdata1), .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1), .owner(owner1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        if_addr = 8'h00; ls_addr = 8'h00; ls_wdata = 8'h00;
        tick(); tick();
        checks++; if ({if_ack0, ls_ack0, mem_rd0, mem_wr0, busy0, owner0} !== 6'b0)
            begin errors++; $display("FAIL reset_ctl0 got %b exp 000000", {if_ack0, ls_ack0, mem_rd0, mem_wr0, busy0, owner0}); end
        checks++; if ({rdata0, mem_addr0, mem_wdata0} !== 24'h0)
            begin errors++; $display("FAIL reset_data0 got %h exp 000000", {rdata0, mem_addr0, mem_wdata0}); end
        checks++; if ({if_ack1, ls_ack1, mem_rd1, mem_wr1, busy1, owner1, rdata1} !== 14'b0)
            begin errors++; $display("FAIL reset_dut1 got %h exp 0", {if_ack1, ls_ack1, mem_rd1, mem_wr1, busy1, owner1, rdata1}); end
    endtask

    task automatic test_if_read();
        reset = 1'b1; if_req = 1'b1; if_addr = 8'h10;
        tick();
        checks++; if ({mem_rd0, mem_wr0, busy0, owner0, if_ack0} !== 5'b10100)
            begin errors++; $display("FAIL rd_acc1 got %b exp 10100", {mem_rd0, mem_wr0, busy0, owner0, if_ack0}); end
        checks++; if (mem_addr0 !== 8'h10)
            begin errors++; $display("FAIL rd_addr got %h exp 10", mem_addr0); end
        tick();
        checks++; if ({mem_rd0, if_ack0} !== 2'b10)
            begin errors++; $display("FAIL rd_acc2 got %b exp 10", {mem_rd0, if_ack0}); end
        tick();
        checks++; if ({mem_rd0, if_ack0, ls_ack0, busy0} !== 4'b0101)
            begin errors++; $display("FAIL rd_resp got %b exp 0101", {mem_rd0, if_ack0, ls_ack0, busy0}); end
        checks++; if (rdata0 !== 8'hA5)
            begin errors++; $display("FAIL rd_rdata got %h exp a5", rdata0); end
        if_req = 1'b0;
        tick();
        checks++; if ({if_ack0, busy0, mem_rd0} !== 3'b000)
            begin errors++; $display("FAIL rd_idle got %b exp 000", {if_ack0, busy0, mem_rd0}); end
    endtask

    task automatic test_ls_write();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h20; ls_wdata = 8'h3C;
        tick();
        checks++; if ({mem_rd0, mem_wr0, busy0, owner0} !== 4'b0111)
            begin errors++; $display("FAIL wr_acc1 got %b exp 0111", {mem_rd0, mem_wr0, busy0, owner0}); end
        checks++; if ({mem_addr0, mem_wdata0} !== 16'h203C)
            begin errors++; $display("FAIL wr_bus got %h exp 203c", {mem_addr0, mem_wdata0}); end
        ls_addr = 8'h77; ls_wdata = 8'hEE;
        tick();
        checks++; if ({mem_rd0, mem_wr0, mem_wdata0} !== 10'b01_0011_1100)
            begin errors++; $display("FAIL wr_acc2 got %b exp 0100111100", {mem_rd0, mem_wr0, mem_wdata0}); end
        tick();
        checks++; if ({mem_wr0, ls_ack0, if_ack0} !== 3'b010)
            begin errors++; $display("FAIL wr_resp got %b exp 010", {mem_wr0, ls_ack0, if_ack0}); end
        checks++; if (rdata0 !== 8'hA5)
            begin errors++; $display("FAIL wr_rdata got %h exp a5", rdata0); end
        ls_req = 1'b0; ls_we = 1'b0;
        tick();
        checks++; if ({ls_ack0, busy0} !== 2'b00)
            begin errors++; $display("FAIL wr_idle got %b exp 00", {ls_ack0, busy0}); end
    endtask

    task automatic test_contention();
        logic exp_ls;
        reset = 1'b0; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
        if_addr = 8'h10; ls_addr = 8'h44;
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_LS_PRIORITY_EN
            exp_ls = 1'b1;
`else
            exp_ls = (i % 2) == 1;
`endif
            tick();
            checks++; if ({mem_rd0, busy0, owner0} !== {2'b11, exp_ls})
                begin errors++; $display("FAIL arb_owner%0d got %b exp %b", i, {mem_rd0, busy0, owner0}, {2'b11, exp_ls}); end
            checks++; if (mem_addr0 !== (exp_ls ? 8'h44 : 8'h10))
                begin errors++; $display("FAIL arb_addr%0d got %h exp %h", i, mem_addr0, exp_ls ? 8'h44 : 8'h10); end
            tick(); tick();
            checks++; if ({if_ack0, ls_ack0} !== {!exp_ls, exp_ls})
                begin errors++; $display("FAIL arb_ack%0d got %b exp %b", i, {if_ack0, ls_ack0}, {!exp_ls, exp_ls}); end
            checks++; if (rdata0 !== (exp_ls ? 8'h5A : 8'hA5))
                begin errors++; $display("FAIL arb_rdata%0d got %h exp %h", i, rdata0, exp_ls ? 8'h5A : 8'hA5); end
            tick();
            checks++; if ({if_ack0, ls_ack0, busy0} !== 3'b000)
                begin errors++; $display("FAIL arb_idle%0d got %b exp 000", i, {if_ack0, ls_ack0, busy0}); end
        end
        ls_req = 1'b0;
        tick();
        checks++; if ({mem_rd0, owner0} !== 2'b10)
            begin errors++; $display("FAIL arb_if_after got %b exp 10", {mem_rd0, owner0}); end
        tick(); tick();
        checks++; if ({if_ack0, ls_ack0, rdata0} !== {2'b10, 8'hA5})
            begin errors++; $display("FAIL arb_if_ack got %h exp 2a5", {if_ack0, ls_ack0, rdata0}); end
    endtask

    task automatic test_reset_abort();
        tick();
        tick();
        tick();
        checks++; if ({mem_rd0, busy0, owner0} !== 3'b110)
            begin errors++; $display("FAIL abort_pre got %b exp 110", {mem_rd0, busy0, owner0}); end
        reset = 1'b0;
        tick();
        checks++; if ({mem_rd0, if_ack0, busy0} !== 3'b000)
            begin errors++; $display("FAIL abort_ctl got %b exp 000", {mem_rd0, if_ack0, busy0}); end
        checks++; if (rdata0 !== 8'h00)
            begin errors++; $display("FAIL abort_rdata got %h exp 00", rdata0); end
        if_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++; if ({if_ack0, ls_ack0, mem_rd0} !== 3'b000)
            begin errors++; $display("FAIL abort_noack got %b exp 000", {if_ack0, ls_ack0, mem_rd0}); end
    endtask

    task automatic test_back_to_back_lat1();
        reset = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        tick();
        reset = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h44;
        tick();
        checks++; if ({mem_rd1, busy1, owner1, mem_addr1} !== {3'b111, 8'h44})
            begin errors++; $display("FAIL l1_ls_acc got %h exp 744", {mem_rd1, busy1, owner1, mem_addr1}); end
        if_req = 1'b1; if_addr = 8'h30;
        tick();
        checks++; if ({mem_rd1, ls_ack1, if_ack1} !== 3'b010)
            begin errors++; $display("FAIL l1_ls_resp got %b exp 010", {mem_rd1, ls_ack1, if_ack1}); end
        checks++; if (rdata1 !== 8'h5A)
            begin errors++; $display("FAIL l1_ls_rdata got %h exp 5a", rdata1); end
        ls_req = 1'b0;
        tick();
        checks++; if ({mem_rd1, busy1, if_ack1, ls_ack1} !== 4'b0000)
            begin errors++; $display("FAIL l1_idle got %b exp 0000", {mem_rd1, busy1, if_ack1, ls_ack1}); end
        tick();
        checks++; if ({mem_rd1, owner1, mem_addr1} !== {2'b10, 8'h30})
            begin errors++; $display("FAIL l1_if_acc got %h exp 230", {mem_rd1, owner1, mem_addr1}); end
        if_req = 1'b0;
        tick();
        checks++; if ({mem_rd1, if_ack1, rdata1} !== {2'b01, 8'hC3})
            begin errors++; $display("FAIL l1_if_resp got %h exp 1c3", {mem_rd1, if_ack1, rdata1}); end
        tick();
        checks++; if ({if_ack1, busy1} !== 2'b00)
            begin errors++; $display("FAIL l1_end got %b exp 00", {if_ack1, busy1}); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5;
        mem[8'h44] = 8'h5A;
        mem[8'h30] = 8'hC3;
        test_reset();
        test_if_read();
        test_ls_write();
        test_contention();
        test_reset_abort();
        test_back_to_back_lat1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
